// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side and shared-memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory view.
interface mem_arbiter_if;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
               pmem_wdata, busy
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
               pmem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto one line-wide memory port.
// Define MEM_ARBITER_FAIR_EN for alternating grants on contention; default is D-cache priority.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          grant_i;
    logic          grant_d;
    logic          resp_i;
    logic          resp_d;
    logic          prefer_d;
    logic          want_i;
    logic          want_d;
    logic          pmem_read_q;
    logic          pmem_write_q;
    logic          busy_q;
    logic [31:0]   addr_q;
    logic [255:0]  wdata_q;

    assign want_i = bus.i_read;
    assign want_d = bus.d_read | bus.d_write;

`ifdef MEM_ARBITER_FAIR_EN
    // 1'b1 = D-cache was served last; reset value means I-cache
    logic last_d;

    // Last-served tracker, updated on every completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (resp_d) begin
            last_d <= 1'b1;
        end else if (resp_i) begin
            last_d <= 1'b0;
        end else begin
            last_d <= last_d;
        end
    end

    assign prefer_d = ~last_d;
`else
    assign prefer_d = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, grant and completion steering
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        resp_i     = 1'b0;
        resp_d     = 1'b0;
        case (state)
            IDLE: begin
                if (want_d && (prefer_d || !want_i)) begin
                    next_state = SERVE_D;
                    grant_d    = 1'b1;
                end else if (want_i) begin
                    next_state = SERVE_I;
                    grant_i    = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            SERVE_I: begin
                if (bus.pmem_resp) begin
                    resp_i     = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = SERVE_I;
                end
            end
            SERVE_D: begin
                if (bus.pmem_resp) begin
                    resp_d     = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = SERVE_D;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Transaction latch: the memory port is driven only from these registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 256'd0;
        end else if (grant_d) begin
            pmem_read_q  <= ~bus.d_write;
            pmem_write_q <= bus.d_write;
            busy_q       <= 1'b1;
            addr_q       <= bus.d_addr;
            wdata_q      <= bus.d_wdata;
        end else if (grant_i) begin
            pmem_read_q  <= 1'b1;
            pmem_write_q <= 1'b0;
            busy_q       <= 1'b1;
            addr_q       <= bus.i_addr;
            wdata_q      <= wdata_q;
        end else if (resp_i || resp_d) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= addr_q;
            wdata_q      <= wdata_q;
        end else begin
            pmem_read_q  <= pmem_read_q;
            pmem_write_q <= pmem_write_q;
            busy_q       <= busy_q;
            addr_q       <= addr_q;
            wdata_q      <= wdata_q;
        end
    end

    assign bus.pmem_read  = pmem_read_q;
    assign bus.pmem_write = pmem_write_q;
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.i_resp     = resp_i;
    assign bus.d_resp     = resp_d;
    // Read data is broadcast; only the resp strobes select the receiver
    assign bus.i_rdata    = bus.pmem_rdata;
    assign bus.d_rdata    = bus.pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays both caches and memory.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_read     = 1'b0;
        bus.i_addr     = 32'h0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = 32'h0;
        bus.d_wdata    = 256'd0;
        bus.pmem_rdata = 256'd0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        #3;
        rst = 1'b0;
        #1;
        nvec++;
        if ({bus.pmem_read, bus.pmem_write, bus.busy, bus.i_resp, bus.d_resp} !== 5'b00000) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.pmem_read, bus.pmem_write, bus.busy, bus.i_resp, bus.d_resp});
        end
        nvec++;
        if (bus.pmem_addr !== 32'h0 || bus.pmem_wdata !== 256'd0) begin
            nerr++;
            $display("FAIL reset_latch: addr %h wdata %h expected zero", bus.pmem_addr, bus.pmem_wdata);
        end
        tick();
        tick();
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_lone_i;
        logic [255:0] line;
        line = {8{32'hC0DE_0040}};
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0040;
        tick();
        nvec++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h40 || bus.busy !== 1'b1) begin
            nerr++;
            $display("FAIL lone_i_grant: rd %b wr %b addr %h busy %b expected 1 0 00000040 1",
                     bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.busy);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++;
            if (bus.pmem_read !== 1'b1 || bus.i_resp !== 1'b0) begin
                nerr++;
                $display("FAIL lone_i_wait%0d: rd %b i_resp %b expected 1 0", k, bus.pmem_read, bus.i_resp);
            end
        end
        tick();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line;
        #1;
        nvec++;
        if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== line) begin
            nerr++;
            $display("FAIL lone_i_resp: i_resp %b d_resp %b i_rdata %h expected 1 0 %h",
                     bus.i_resp, bus.d_resp, bus.i_rdata, line);
        end
        tick();
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        #1;
        nvec++;
        if (bus.pmem_read !== 1'b0 || bus.busy !== 1'b0 || bus.i_resp !== 1'b0) begin
            nerr++;
            $display("FAIL lone_i_idle: rd %b busy %b i_resp %b expected 0 0 0",
                     bus.pmem_read, bus.busy, bus.i_resp);
        end
        tick();
    endtask

    task automatic test_priority;
        logic [255:0] wline;
        wline = {8{32'hDA7A_0100}};
        bus.i_read  = 1'b1;
        bus.i_addr  = 32'h0000_0080;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = wline;
        tick();
        nvec++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_addr !== 32'h100 || bus.pmem_wdata !== wline) begin
            nerr++;
            $display("FAIL prio_d_first: wr %b rd %b addr %h expected 1 0 00000100", bus.pmem_write, bus.pmem_read, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1;
        #1;
        nvec++;
        if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin
            nerr++;
            $display("FAIL prio_d_resp: d_resp %b i_resp %b expected 1 0", bus.d_resp, bus.i_resp);
        end
        tick();
        bus.pmem_resp = 1'b0;
        bus.d_write   = 1'b0;
        #1;
        nvec++;
        if (bus.busy !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            nerr++;
            $display("FAIL prio_gap: busy %b rd %b wr %b expected 0 0 0", bus.busy, bus.pmem_read, bus.pmem_write);
        end
        tick();
        nvec++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h80) begin
            nerr++;
            $display("FAIL prio_i_second: rd %b wr %b addr %h expected 1 0 00000080", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        tick();
    endtask

    task automatic test_both_write_read;
        // d_read with d_write at grant is a writeback
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_0500;
        tick();
        nvec++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin
            nerr++;
            $display("FAIL rw_as_write: wr %b rd %b expected 1 0", bus.pmem_write, bus.pmem_read);
        end
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        tick();
    endtask

    task automatic test_alternate;
        logic exp_d [4];
`ifdef MEM_ARBITER_FAIR_EN
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_1000;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++;
            if (bus.pmem_addr !== (exp_d[k] ? 32'h2000 : 32'h1000) || bus.pmem_read !== 1'b1) begin
                nerr++;
                $display("FAIL alt_grant%0d: addr %h rd %b expected %h 1", k, bus.pmem_addr, bus.pmem_read,
                         exp_d[k] ? 32'h2000 : 32'h1000);
            end
            bus.pmem_resp = 1'b1;
            #1;
            nvec++;
            if (bus.d_resp !== exp_d[k] || bus.i_resp !== ~exp_d[k]) begin
                nerr++;
                $display("FAIL alt_resp%0d: d_resp %b i_resp %b expected %b %b", k, bus.d_resp, bus.i_resp,
                         exp_d[k], ~exp_d[k]);
            end
            tick();
            bus.pmem_resp = 1'b0;
            #1;
            nvec++;
            if (bus.busy !== 1'b0 || bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
                nerr++;
                $display("FAIL alt_gap%0d: busy %b i_resp %b d_resp %b expected 0 0 0", k, bus.busy, bus.i_resp, bus.d_resp);
            end
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        tick();
    endtask

    task automatic test_lone_d_read;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0600;
        tick();
        nvec++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h600) begin
            nerr++;
            $display("FAIL lone_d_read: rd %b wr %b addr %h expected 1 0 00000600", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        bus.d_read    = 1'b0;
        tick();
    endtask

    task automatic test_stable_addr;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0200;
        tick();
        bus.d_addr  = 32'h0000_0300;
        bus.d_write = 1'b1;
        bus.d_read  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            nvec++;
            if (bus.pmem_addr !== 32'h200 || bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin
                nerr++;
                $display("FAIL stable_addr%0d: addr %h rd %b wr %b expected 00000200 1 0", k,
                         bus.pmem_addr, bus.pmem_read, bus.pmem_write);
            end
        end
        bus.pmem_resp = 1'b1;
        #1;
        nvec++;
        if (bus.d_resp !== 1'b1 || bus.pmem_addr !== 32'h200) begin
            nerr++;
            $display("FAIL stable_resp: d_resp %b addr %h expected 1 00000200", bus.d_resp, bus.pmem_addr);
        end
        tick();
        bus.pmem_resp = 1'b0;
        bus.d_write   = 1'b0;
        tick();
    endtask

    task automatic test_reset_inflight;
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0400;
        tick();
        tick();
        #2;
        rst = 1'b0;
        bus.pmem_resp = 1'b1;
        #1;
        nvec++;
        if (bus.pmem_read !== 1'b0 || bus.busy !== 1'b0 || bus.i_resp !== 1'b0 || bus.pmem_addr !== 32'h0) begin
            nerr++;
            $display("FAIL rst_inflight: rd %b busy %b i_resp %b addr %h expected 0 0 0 00000000",
                     bus.pmem_read, bus.busy, bus.i_resp, bus.pmem_addr);
        end
        bus.i_read    = 1'b0;
        bus.pmem_resp = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        tick();
        bus.pmem_resp = 1'b1;
        #1;
        nvec++;
        if (bus.pmem_read !== 1'b0 || bus.busy !== 1'b0 || bus.i_resp !== 1'b0) begin
            nerr++;
            $display("FAIL rst_after: rd %b busy %b i_resp %b expected 0 0 0", bus.pmem_read, bus.busy, bus.i_resp);
        end
        tick();
        bus.pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_idle_resp;
        logic [255:0] line;
        line = {8{32'h1D1E_5A5A}};
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line;
        #1;
        nvec++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0 || bus.d_rdata !== line || bus.i_rdata !== line) begin
            nerr++;
            $display("FAIL idle_resp: i_resp %b d_resp %b d_rdata %h expected 0 0 %h",
                     bus.i_resp, bus.d_resp, bus.d_rdata, line);
        end
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        nvec++;
        if (bus.busy !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            nerr++;
            $display("FAIL idle_stay: busy %b rd %b wr %b expected 0 0 0", bus.busy, bus.pmem_read, bus.pmem_write);
        end
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0700;
        tick();
        nvec++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h700) begin
            nerr++;
            $display("FAIL idle_then_grant: rd %b addr %h expected 1 00000700", bus.pmem_read, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        bus.d_read    = 1'b0;
        tick();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_lone_i();
        test_priority();
        test_both_write_read();
        test_lone_d_read();
        test_alternate();
        test_stable_addr();
        test_reset_inflight();
        test_idle_resp();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 rst  input  1  Reset, asynchronous, active-low: 0 = reset asserted.
REQ-003 i_read  input  1  Instruction-cache line read request; held until i_resp.
REQ-004 i_addr  input  32  Instruction-cache line address, 32-byte aligned.
REQ-005 i_rdata  output  256  Line returned to the instruction cache.
REQ-006 i_resp  output  1  One-cycle completion pulse to the instruction cache.
REQ-007 d_read  input  1  Data-cache line read request; held until d_resp.
REQ-008 d_write  input  1  Data-cache line writeback request; held until d_resp.
REQ-009 d_addr  input  32  Data-cache line address, 32-byte aligned.
REQ-010 d_wdata  input  256  Data-cache writeback line.
REQ-011 d_rdata  output  256  Line returned to the data cache.
REQ-012 d_resp  output  1  One-cycle completion pulse to the data cache.
REQ-013 pmem_read  output  1  Read request to the shared memory port.
REQ-014 pmem_write  output  1  Write request to the shared memory port.
REQ-015 pmem_addr  output  32  Shared memory port address.
REQ-016 pmem_wdata  output  256  Shared memory port write line.
REQ-017 pmem_rdata  input  256  Shared memory port read line; valid when pmem_resp = 1.
REQ-018 pmem_resp  input  1  Shared memory port completion; one cycle per transaction.
REQ-019 busy  output  1  High while in a SERVE state.

Function
REQ-020 States SHALL be IDLE, SERVE_I, SERVE_D; encoding is registered.
REQ-021 IDLE: if d_read|d_write -> SERVE_D; else if i_read -> SERVE_I; else stay (priority subject to REQ-033).
REQ-022 On the grant edge, the arbiter SHALL latch address, operation and d_wdata into internal registers; pmem_* outputs SHALL be driven only from these registers.
REQ-023 Latency: request seen in IDLE at cycle N -> pmem_read/pmem_write high at cycle N+1.
REQ-024 In SERVE_I: pmem_read=1, pmem_write=0. In SERVE_D: exactly one of pmem_read/pmem_write high, per the latched op.
REQ-025 d_read and d_write both high at grant SHALL be treated as a write.
REQ-026 pmem_resp in SERVE_x SHALL produce x_resp=1 in the same cycle (combinational), with x_rdata = pmem_rdata; next state IDLE.
REQ-027 At most one of i_resp/d_resp SHALL be high in any cycle; pmem_resp in IDLE SHALL be ignored.
REQ-028 Every transaction SHALL be followed by at least one IDLE cycle, so a request dropped after its resp is never re-granted.
REQ-029 Requests that change or deassert while in a SERVE state SHALL NOT affect the in-flight transaction.
REQ-030 i_rdata and d_rdata SHALL equal pmem_rdata at all times; only the resp lines are steered.
REQ-031 The arbiter SHALL NOT time out; it waits indefinitely for pmem_resp.

Reset
REQ-032 rst=0 SHALL immediately (asynchronously) force IDLE, pmem_read=0, pmem_write=0, busy=0, i_resp=0, d_resp=0, latched address/data = 0, last-served = I; an in-flight transaction is abandoned and no resp is issued for it.

Configuration
REQ-033 Macro MEM_ARBITER_FAIR_EN. Defined: when both caches request in IDLE, grant the cache not served last (last-served register updated on each resp). Undefined: fixed data-cache priority; the last-served register is absent.

Verification
REQ-034 Lone i_read, i_addr=0x0000_0040, pmem_resp 5 cycles after pmem_read -> pmem_addr=0x40, i_resp pulses once with i_rdata = pmem_rdata, then IDLE.
REQ-035 i_read and d_write (d_addr=0x100) asserted in the same cycle, macro undefined -> SERVE_D first (pmem_write=1, pmem_addr=0x100), then SERVE_I after one IDLE cycle.
REQ-036 Macro defined, both requesting continuously, last-served=D -> grants alternate I, D, I, D; each resp is a single cycle.
REQ-037 d_addr changed from 0x200 to 0x300 mid-SERVE_D -> pmem_addr stays 0x200 until d_resp.
REQ-038 rst=0 two cycles into SERVE_I -> pmem_read drops before the next clock edge, no i_resp is issued, and the arbiter is in IDLE after rst=1.
REQ-039 pmem_resp pulsed while in IDLE -> no i_resp/d_resp and no state change.
